interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 30 +++
 rtl/interrupt_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module   : interrupt_controller_if
// Brief    : Configuration register bus between a bus master and the
//            interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface interrupt_controller_if;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module   : interrupt_controller
// Brief    : Single-level, non-nesting, fixed-priority interrupt controller
//            with edge-detected pending bits, mask and global enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int NUM_IRQ = 8
) (
    input  wire               clk,
    input  wire               reset,
    input  wire [NUM_IRQ-1:0] irq_req,
    input  wire               instr_step,
    input  wire               ret_i,
    interrupt_controller_if.slave cfg,
    output logic              int_mux,
    output logic              in_service,
    output logic [2:0]        int_id
);

    localparam logic [7:0] c_VALID = 8'((16'd1 << NUM_IRQ) - 16'd1);

    localparam logic [1:0] c_ADDR_MASK = 2'd0;
    localparam logic [1:0] c_ADDR_PEND = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL = 2'd2;
    localparam logic [1:0] c_ADDR_ID   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_VECTOR  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_samp;
    logic [7:0] r_samp_d;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic       r_gie;
    logic       r_int_mux;
    logic       r_in_service;
    logic [2:0] r_int_id;

    logic [7:0] w_irq8;
    logic [7:0] w_edge;
    logic [7:0] w_cand;
    logic [7:0] w_ack;
    logic [7:0] w_w1c;
    logic [7:0] w_pend_nxt;
    logic [2:0] w_first_id;
    logic       w_wr_mask;
    logic       w_wr_pend;
    logic       w_wr_ctrl;
    logic [7:0] w_rdata;

    // Widen the request vector to the 8-bit register width; unused lanes tie low.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_irq
            if (gi < NUM_IRQ) begin : g_used
                assign w_irq8[gi] = irq_req[gi];
            end else begin : g_unused
                assign w_irq8[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_wr_mask  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_MASK);
    assign w_wr_pend  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_PEND);
    assign w_wr_ctrl  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_CTRL);

    assign w_edge     = r_samp & ~r_samp_d;
    assign w_cand     = r_pend & r_mask;
    assign w_ack      = ((r_state == S_VECTOR) && instr_step) ? (8'd1 << r_int_id) : 8'd0;
    assign w_w1c      = w_wr_pend ? cfg.cfg_wdata : 8'd0;
    // A fresh edge overrides any clear landing on the same bit.
    assign w_pend_nxt = ((r_pend & ~w_w1c & ~w_ack) | w_edge) & c_VALID;

    always_comb begin
        w_first_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_first_id = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp   <= 8'd0;
            r_samp_d <= 8'd0;
            r_pend   <= 8'd0;
            r_mask   <= 8'd0;
        end else begin
            r_samp   <= w_irq8;
            r_samp_d <= r_samp;
            r_pend   <= w_pend_nxt;
            if (w_wr_mask) begin
                r_mask <= cfg.cfg_wdata & c_VALID;
            end
        end
    end

    // Hardware GIE updates (vector entry, return) take precedence over a
    // simultaneous software write to CTRL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_gie        <= 1'b0;
            r_int_mux    <= 1'b0;
            r_in_service <= 1'b0;
            r_int_id     <= 3'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_gie <= cfg.cfg_wdata[0];
            end
            case (r_state)
                S_IDLE: begin
                    if (r_gie && (w_cand != 8'd0)) begin
                        r_state   <= S_VECTOR;
                        r_int_mux <= 1'b1;
                        r_int_id  <= w_first_id;
                        r_gie     <= 1'b0;
                    end
                end
                S_VECTOR: begin
                    if (instr_step) begin
                        r_state      <= S_SERVICE;
                        r_int_mux    <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (ret_i) begin
                        r_state      <= S_IDLE;
                        r_in_service <= 1'b0;
                        r_gie        <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_int_mux    <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'd0;
        case (cfg.cfg_addr)
            c_ADDR_MASK: w_rdata = r_mask;
            c_ADDR_PEND: w_rdata = r_pend;
            c_ADDR_CTRL: w_rdata = {6'd0, r_in_service, r_gie};
            c_ADDR_ID:   w_rdata = {5'd0, r_int_id};
            default:     w_rdata = 8'd0;
        endcase
    end

    assign cfg.cfg_rdata = w_rdata;
    assign int_mux       = r_int_mux;
    assign in_service    = r_in_service;
    assign int_id        = r_int_id;

endmodule

`default_nettype wire
